// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package mdu_pkg;

   localparam int MDU_DATA_WIDTH = 32;
   localparam int MDU_ADDR_WIDTH = 5;
   localparam int MDU_ITERS      = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_FIX,
      ST_DONE
   } mdu_state_e;

   function automatic logic op_is_mul(input logic [2:0] op);
      return !op[2];
   endfunction

   // MUL takes unsigned operands: its low product word is sign-agnostic.
   function automatic logic op_a_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_b_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes: start loads operands, each step
// retires one quotient bit, MSB first.
module mdu_div_core
   import mdu_pkg::*;
#(
   parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  start,
   input  logic                  step,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder
);
   localparam int W = DATA_WIDTH;

   logic [W-1:0] quo_q, rem_q, div_q;
   logic [W:0]   r_sh, r_sub;
   logic         fits;

   // r_sh never reaches 2*divisor, so the top bit of the difference is the borrow
   always_comb begin
      r_sh  = {rem_q, quo_q[W-1]};
      r_sub = r_sh - {1'b0, div_q};
      fits  = !r_sub[W];
   end

   always_ff @(posedge clk) begin
      if (start) begin
         quo_q <= dividend;
         rem_q <= '0;
         div_q <= divisor;
      end else if (step) begin
         quo_q <= {quo_q[W-2:0], fits};
         rem_q <= fits ? r_sub[W-1:0] : r_sh[W-1:0];
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/mdu_unit.sv
// RV32M multiply/divide unit: 32-step iterative datapaths, one-cycle sign fix-up.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier that bypasses BUSY.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int DATA_WIDTH = MDU_DATA_WIDTH,
   parameter int ADDR_WIDTH = MDU_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] rs1_val,
   input  logic [DATA_WIDTH-1:0] rs2_val,
   input  logic [ADDR_WIDTH-1:0] rd_in,
   input  logic                  kill,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic [ADDR_WIDTH-1:0] rd_out
);
   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(MDU_ITERS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_ITERS - 1);

   function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic sgn);
      return (sgn && x[W-1]) ? -x : x;
   endfunction

   function automatic logic signed [W-1:0] sign_w(input logic [W-1:0] mag, input logic neg);
      logic signed [W-1:0] v;
      v = $signed(mag);
      return neg ? -v : v;
   endfunction

   function automatic logic signed [2*W-1:0] sign_2w(input logic [2*W-1:0] mag, input logic neg);
      logic signed [2*W-1:0] v;
      v = $signed(mag);
      return neg ? -v : v;
   endfunction

   mdu_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic                   accept, core_step;
   mdu_op_e                op_q;
   logic [W-1:0]           a_q, b_q;
   logic [ADDR_WIDTH-1:0]  rd_q;
   logic                   a_neg, b_neg, b_zero;
   logic [W-1:0]           in_mag_a, in_mag_b, quo, rem;
   logic [2*W-1:0]         prod_u;
   logic signed [2*W-1:0]  prod_s;
   logic signed [W-1:0]    quo_s, rem_s;
   logic [W-1:0]           fix_result;

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign accept    = in_valid && in_ready && !kill;
   assign core_step = (state_q == ST_BUSY);
   assign in_mag_a  = magnitude(rs1_val, op_a_signed(op));
   assign in_mag_b  = magnitude(rs2_val, op_b_signed(op));

   assign a_neg  = op_a_signed(op_q) && a_q[W-1];
   assign b_neg  = op_b_signed(op_q) && b_q[W-1];
   assign b_zero = (b_q == '0);

   mdu_div_core #(
      .DATA_WIDTH (W)
   ) u_div (
      .clk       (clk),
      .start     (accept),
      .step      (core_step),
      .dividend  (in_mag_a),
      .divisor   (in_mag_b),
      .quotient  (quo),
      .remainder (rem)
   );

`ifdef MDU_FAST_MUL_EN
   localparam logic FAST_MUL = 1'b1;

   assign prod_u = (2*W)'(magnitude(a_q, op_a_signed(op_q))) *
                   (2*W)'(magnitude(b_q, op_b_signed(op_q)));
`else
   localparam logic FAST_MUL = 1'b0;

   logic [2*W-1:0] mul_acc_q;
   logic [W-1:0]   mul_mcand_q;
   logic [W:0]     mul_sum;

   // {hi, lo}: lo starts as the multiplier and drains out as hi accumulates
   always_comb mul_sum = {1'b0, mul_acc_q[2*W-1:W]} + (mul_acc_q[0] ? {1'b0, mul_mcand_q} : '0);

   always_ff @(posedge clk) begin
      if (accept) begin
         mul_acc_q   <= {{W{1'b0}}, in_mag_b};
         mul_mcand_q <= in_mag_a;
      end else if (core_step) begin
         mul_acc_q   <= {mul_sum, mul_acc_q[W-1:1]};
      end
   end

   assign prod_u = mul_acc_q;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = (FAST_MUL && op_is_mul(op)) ? ST_FIX : ST_BUSY;
         ST_BUSY: if (cnt_q == CNT_LAST) state_d = ST_FIX;
         ST_FIX:  state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (kill) state_d = ST_IDLE;
   end

   // Divide by zero bypasses the magnitude path; overflow falls out naturally.
   always_comb begin
      prod_s     = sign_2w(prod_u, a_neg ^ b_neg);
      quo_s      = sign_w(quo, a_neg ^ b_neg);
      rem_s      = sign_w(rem, a_neg);
      fix_result = '0;
      case (op_q)
         OP_MUL:                       fix_result = prod_s[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_s[2*W-1:W];
         OP_DIV, OP_DIVU:              fix_result = b_zero ? '1 : quo_s;
         default:                      fix_result = b_zero ? a_q : rem_s;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_q <= mdu_op_e'(op);
         a_q  <= rs1_val;
         b_q  <= rs2_val;
         rd_q <= rd_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         result  <= '0;
         rd_out  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= (state_q == ST_BUSY && state_d == ST_BUSY) ? cnt_q + 1'b1 : '0;
         if (state_q == ST_FIX && !kill) begin
            result <= fix_result;
            rd_out <= rd_q;
         end
      end
   end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: arithmetic corner cases, handshake hold,
// kill and asynchronous reset during an operation.
module tb_mdu_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, kill, out_ready;
   logic [2:0]  op;
   logic [31:0] rs1_val, rs2_val;
   logic [4:0]  rd_in;
   logic        in_ready, out_valid;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int total = 0;
   int bad   = 0;

   mdu_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .rs1_val   (rs1_val),
      .rs2_val   (rs2_val),
      .rd_in     (rd_in),
      .kill      (kill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .rd_out    (rd_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Edge count with the accept edge as edge 1.
   function automatic int exp_lat(input logic [2:0] o);
`ifdef MDU_FAST_MUL_EN
      return (o[2] == 1'b0) ? 2 : 34;
`else
      return (o[2] == 1'b0) ? 34 : 34;
`endif
   endfunction

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      op       = o;
      rs1_val  = a;
      rs2_val  = b;
      rd_in    = rd;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int edges);
      edges = 1;
      while (!out_valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic count_valid(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         if (out_valid) seen++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
      int e;
      issue(o, a, b, rd);
      wait_done(e);
      check({tag, ".lat"}, e, exp_lat(o));
      check({tag, ".res"}, result, exp);
      check({tag, ".rd"}, {27'd0, rd_out}, {27'd0, rd});
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ".idle"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int e;
      int seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      kill      = 1'b0;
      out_ready = 1'b0;
      op        = 3'd0;
      rs1_val   = '0;
      rs2_val   = '0;
      rd_in     = '0;
      #1;
      check("rst.in_ready", {31'd0, in_ready}, 32'd1);
      check("rst.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst.result", result, 32'd0);
      check("rst.rd_out", {27'd0, rd_out}, 32'd0);
      check("rst.cnt", {27'd0, dut.cnt_q}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run("div_neg7_2",  OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD);
      run("rem_neg7_2",  OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF);
      run("remu_div0",   OP_REMU,   32'd100,       32'd0,         5'd7,  32'd100);
      run("divu_div0",   OP_DIVU,   32'd100,       32'd0,         5'd8,  32'hFFFF_FFFF);
      run("div_div0",    OP_DIV,    32'hFFFF_FFF9, 32'd0,         5'd9,  32'hFFFF_FFFF);
      run("rem_div0",    OP_REM,    32'hFFFF_FFF9, 32'd0,         5'd10, 32'hFFFF_FFF9);
      run("div_ovf",     OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
      run("rem_ovf",     OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);
      run("divu_100_7",  OP_DIVU,   32'd100,       32'd7,         5'd13, 32'd14);
      run("remu_100_7",  OP_REMU,   32'd100,       32'd7,         5'd14, 32'd2);
      run("mulhu_ones",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE);
      run("mul_ones",    OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'h0000_0001);
      run("mulh_ones",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000);
      run("mulhsu_ones", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'hFFFF_FFFF);
      run("mulh_min",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd19, 32'h4000_0000);
      run("mul_rd0",     OP_MUL,    32'd3,         32'd5,         5'd0,  32'd15);

      // DONE holds while writeback stalls
      issue(OP_DIVU, 32'd100, 32'd7, 5'd9);
      wait_done(e);
      check("hold.lat", e, 32'd34);
      for (int i = 0; i < 5; i++) begin
         check("hold.res", result, 32'd14);
         check("hold.rd", {27'd0, rd_out}, 32'd9);
         check("hold.in_ready", {31'd0, in_ready}, 32'd0);
         check("hold.out_valid", {31'd0, out_valid}, 32'd1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("hold.rel_valid", {31'd0, out_valid}, 32'd0);
      check("hold.rel_ready", {31'd0, in_ready}, 32'd1);

      // kill at iteration 10 of DIVU
      issue(OP_DIVU, 32'd1000, 32'd3, 5'd7);
      repeat (10) @(posedge clk);
      #1;
      check("kill.busy", {31'd0, in_ready}, 32'd0);
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill.in_ready", {31'd0, in_ready}, 32'd1);
      check("kill.out_valid", {31'd0, out_valid}, 32'd0);
      count_valid(40, seen);
      check("kill.no_valid", seen, 32'd0);
      run("post_kill", OP_DIVU, 32'd1000, 32'd3, 5'd7, 32'd333);

      // kill wins over a same-cycle accept
      op       = OP_MUL;
      rs1_val  = 32'd3;
      rs2_val  = 32'd5;
      rd_in    = 5'd1;
      in_valid = 1'b1;
      kill     = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      kill     = 1'b0;
      check("kill_acc.in_ready", {31'd0, in_ready}, 32'd1);
      count_valid(40, seen);
      check("kill_acc.no_valid", seen, 32'd0);

      // asynchronous reset in BUSY
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst.in_ready", {31'd0, in_ready}, 32'd1);
      check("arst.out_valid", {31'd0, out_valid}, 32'd0);
      check("arst.result", result, 32'd0);
      check("arst.rd_out", {27'd0, rd_out}, 32'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      count_valid(40, seen);
      check("arst.no_valid", seen, 32'd0);
      run("post_rst", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);

      // kill in DONE overrides the pending writeback
      issue(OP_MUL, 32'd3, 32'd5, 5'd3);
      wait_done(e);
      check("kill_done.valid", {31'd0, out_valid}, 32'd1);
      kill      = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill_done.out_valid", {31'd0, out_valid}, 32'd0);
      check("kill_done.in_ready", {31'd0, in_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set operand and result width.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set destination register tag width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 in_valid  input  1  SHALL flag a request on op/rs1_val/rs2_val/rd_in.
REQ-006 in_ready  output  1  SHALL be high only in IDLE.
REQ-007 op  input  3  SHALL select RV32M: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 rs1_val, rs2_val  input  DATA_WIDTH  SHALL be the operands read from the register file.
REQ-009 rd_in  input  ADDR_WIDTH  SHALL be the destination tag.
REQ-010 kill  input  1  SHALL abort any in-flight operation.
REQ-011 out_valid  output  1  SHALL flag a valid result/rd_out pair.
REQ-012 out_ready  input  1  SHALL be the writeback acceptance signal.
REQ-013 result  output  DATA_WIDTH  SHALL be the computed value, driven as write data to the register file.
REQ-014 rd_out  output  ADDR_WIDTH  SHALL be the captured tag, driven as the register file write address.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY, FIX, DONE.
REQ-016 The request SHALL be accepted on an edge with in_valid && in_ready; op, operands and rd_in are captured; IDLE->BUSY.
REQ-017 BUSY SHALL run exactly 32 iterations, one per cycle:
- MUL group: shift-add on operand magnitudes.
- DIV group: restoring division on operand magnitudes.
- Iteration counter counts 0..31, then BUSY->FIX.
REQ-018 FIX SHALL last one cycle, apply sign correction, select the low or high product word, or quotient/remainder; then FIX->DONE.
REQ-019 out_valid SHALL be high exactly in DONE; it rises on the 34th rising edge after the accept edge.
REQ-020 DONE SHALL hold result and rd_out stable until an edge with out_ready high, then DONE->IDLE.
REQ-021 in_ready SHALL stay low in DONE; there is no back-to-back overlap.
REQ-022 Divide by zero SHALL give quotient all-ones and remainder = rs1_val, for both signed and unsigned.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-024 MULHSU SHALL treat rs1_val as signed and rs2_val as unsigned; the full product is 64 bits.
REQ-025 rd_in = 0 SHALL still execute and produce out_valid; the register file ignores the write.
REQ-026 kill in any state SHALL force IDLE on the next edge with out_valid low; kill overrides a same-cycle accept or out_ready.

Reset
REQ-027 While rst_n is low: state IDLE, in_ready 1, out_valid 0, result 0, rd_out 0, counter 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation with no output.

Configuration
REQ-029 With MDU_FAST_MUL_EN defined:
- MUL group SHALL compute the full product in one cycle and go IDLE->FIX->DONE.
- out_valid then rises on the 2nd edge after accept.
- DIV group is unchanged.
REQ-030 Without MDU_FAST_MUL_EN, all ops SHALL use the 32-iteration path of REQ-017.

Structure
REQ-031 Package mdu_pkg SHALL hold:
- op enum
- FSM state enum
- DATA_WIDTH and ADDR_WIDTH defaults
- iteration count constant (32)
REQ-032 The restoring-division datapath SHALL be sub-module mdu_div_core, with operands, start and step inputs and quotient/remainder outputs; mdu_unit owns the FSM and sign fix-up.

Verification
REQ-033 DIV 0xFFFFFFF9 (-7) / 2, rd_in=5 -> out_valid 34 edges later, result 0xFFFFFFFD, rd_out 5.
REQ-034 REMU 100 / 0 -> result 100; DIVU 100 / 0 -> result 0xFFFFFFFF.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000; REM same operands -> result 0.
REQ-036 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MUL same operands -> result 0x00000001; with MDU_FAST_MUL_EN, out_valid 2 edges after accept.
REQ-037 out_ready held low 5 cycles in DONE -> result/rd_out stable and in_ready low throughout; on out_ready, IDLE next edge.
REQ-038 kill at iteration 10 of DIVU, and separately rst_n pulsed low in BUSY -> IDLE next edge, out_valid never asserted, next request computes correctly.
